// File: rtl/d_sram_like_bridge.sv
// Data-side bridge: MEM-stage SRAM-style port to the sram-like bus (req/addr_ok/data_ok).
// Issues one transaction per enabled access, raises d_stall, and holds read data until the pipeline releases.
module d_sram_like_bridge #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_sram_en,
    input  logic [3:0]        data_sram_wen,
    input  logic [ADDR_W-1:0] data_sram_addr,
    input  logic [DATA_W-1:0] data_sram_wdata,
    output logic [DATA_W-1:0] data_sram_rdata,
    input  logic              flush,
    input  logic              longest_stall,
    output logic              d_stall,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DATA = 2'd1,
        DONE      = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              wen_legal_c;

    // State and read-data buffer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_d  = state_q;
        rdata_d  = rdata_q;
        data_req = 1'b0;
        d_stall  = 1'b0;
        case (state_q)
            IDLE: begin
                data_req = data_sram_en & ~flush;
                d_stall  = data_sram_en & ~flush;
                if (data_req && data_addr_ok) begin
                    state_d = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                d_stall = 1'b1;
                if (data_data_ok) begin
                    if (data_sram_wen == 4'b0000) begin
                        rdata_d = data_rdata;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                // Hold here while any other stall source freezes the pipeline, so the access is not re-issued
                if (!longest_stall) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Transfer size from byte enables; unlisted patterns fall back to word and are flagged
    always_comb begin
        data_size   = 2'd2;
        wen_legal_c = 1'b1;
        case (data_sram_wen)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: data_size = 2'd0;
            4'b0011, 4'b1100:                   data_size = 2'd1;
            4'b1111, 4'b0000:                   data_size = 2'd2;
            default: begin
                data_size   = 2'd2;
                wen_legal_c = 1'b0;
            end
        endcase
    end

    assign data_wr         = |data_sram_wen;
    assign data_addr       = data_sram_addr;
    assign data_wdata      = data_sram_wdata;
    assign data_sram_rdata = rdata_q;

`ifndef SYNTHESIS
    a_wen_legal: assert property (@(posedge clk) disable iff (rst) data_sram_en |-> wen_legal_c)
        else $error("d_sram_like_bridge: illegal byte-enable pattern %b", data_sram_wen);
`endif

endmodule

// File: tb/tb_d_sram_like_bridge.sv
// Directed self-checking bench for d_sram_like_bridge; the bench plays the sram-like slave cycle by cycle.
module tb_d_sram_like_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        flush;
    logic        longest_stall;
    logic        d_stall;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    int req_cycles = 0;
    int handshakes = 0;
    int outstanding = 0;
    int overlap_viol = 0;

    always #5 clk = ~clk;

    d_sram_like_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .flush           (flush),
        .longest_stall   (longest_stall),
        .d_stall         (d_stall),
        .data_req        (data_req),
        .data_wr         (data_wr),
        .data_size       (data_size),
        .data_addr       (data_addr),
        .data_wdata      (data_wdata),
        .data_addr_ok    (data_addr_ok),
        .data_data_ok    (data_data_ok),
        .data_rdata      (data_rdata)
    );

    // Bus monitor: request cycles, handshakes, and any req raised while a transaction is outstanding
    always @(posedge clk) begin
        if (rst) begin
            outstanding = 0;
        end else begin
            if (data_req) req_cycles++;
            if (data_req && outstanding != 0) overlap_viol++;
            if (data_data_ok && outstanding > 0) outstanding--;
            if (data_req && data_addr_ok) begin
                handshakes++;
                outstanding++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1; data_sram_en = 1'b0; data_sram_wen = 4'b0000; data_sram_addr = '0;
        data_sram_wdata = '0; flush = 1'b0; longest_stall = 1'b0; data_addr_ok = 1'b0;
        data_data_ok = 1'b0; data_rdata = '0;
        tick(); tick();
        settle();
        check("reset_d_stall", 32'(d_stall), 32'd0);
        check("reset_req", 32'(data_req), 32'd0);
        check("reset_rdata", data_sram_rdata, 32'h0);
        rst = 1'b0;
        tick();

        // Read word, minimum latency
        data_sram_en = 1'b1; data_sram_wen = 4'b0000; data_sram_addr = 32'h100;
        data_addr_ok = 1'b1; longest_stall = 1'b1;
        settle();
        check("rd_req", 32'(data_req), 32'd1);
        check("rd_stall0", 32'(d_stall), 32'd1);
        check("rd_size", 32'(data_size), 32'd2);
        check("rd_wr", 32'(data_wr), 32'd0);
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h12345678;
        settle();
        check("rd_wait_req", 32'(data_req), 32'd0);
        check("rd_stall1", 32'(d_stall), 32'd1);
        tick();
        data_data_ok = 1'b0; data_rdata = 32'hDEADBEEF; longest_stall = 1'b0;
        settle();
        check("rd_done_stall", 32'(d_stall), 32'd0);
        check("rd_done_req", 32'(data_req), 32'd0);
        check("rd_done_rdata", data_sram_rdata, 32'h12345678);
        check("rd_one_req", 32'(req_cycles), 32'd1);
        tick();
        data_sram_en = 1'b0;

        // Byte write with addr_ok delayed three cycles
        data_sram_en = 1'b1; data_sram_wen = 4'b0100; data_sram_addr = 32'h1002;
        data_sram_wdata = 32'h00AB0000; longest_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data_addr_ok = (i == 3);
            settle();
            check("bw_req", 32'(data_req), 32'd1);
            check("bw_wr", 32'(data_wr), 32'd1);
            check("bw_size", 32'(data_size), 32'd0);
            check("bw_addr", data_addr, 32'h1002);
            check("bw_wdata", data_wdata, 32'h00AB0000);
            check("bw_stall", 32'(d_stall), 32'd1);
            tick();
        end
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h55555555;
        settle();
        check("bw_wait_stall", 32'(d_stall), 32'd1);
        tick();
        data_data_ok = 1'b0; longest_stall = 1'b0;
        settle();
        check("bw_done_stall", 32'(d_stall), 32'd0);
        check("bw_rdata_kept", data_sram_rdata, 32'h12345678);
        tick();
        data_sram_en = 1'b0;

        // Read finishing under a long external stall
        data_sram_en = 1'b1; data_sram_wen = 4'b0000; data_sram_addr = 32'h200;
        data_addr_ok = 1'b1; longest_stall = 1'b1;
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hCAFEF00D;
        tick();
        data_data_ok = 1'b0; data_rdata = 32'h0;
        for (int i = 0; i < 6; i++) begin
            settle();
            check("ls_stall", 32'(d_stall), 32'd0);
            check("ls_req", 32'(data_req), 32'd0);
            check("ls_rdata", data_sram_rdata, 32'hCAFEF00D);
            tick();
        end
        longest_stall = 1'b0;
        tick();

        // Flush in IDLE suppresses the request, flush in WAIT_DATA does not abort
        flush = 1'b1;
        settle();
        check("fl_idle_req", 32'(data_req), 32'd0);
        check("fl_idle_stall", 32'(d_stall), 32'd0);
        flush = 1'b0; data_sram_addr = 32'h204; data_addr_ok = 1'b1;
        settle();
        check("fl_req_back", 32'(data_req), 32'd1);
        tick();
        data_addr_ok = 1'b0; flush = 1'b1;
        settle();
        check("fl_wait_stall", 32'(d_stall), 32'd1);
        check("fl_wait_req", 32'(data_req), 32'd0);
        data_data_ok = 1'b1; data_rdata = 32'h0BADF00D;
        tick();
        data_data_ok = 1'b0; flush = 1'b0; longest_stall = 1'b0;
        settle();
        check("fl_done_stall", 32'(d_stall), 32'd0);
        check("fl_done_rdata", data_sram_rdata, 32'h0BADF00D);
        tick();
        data_sram_en = 1'b0;

        // Stray data_ok in IDLE is ignored
        data_data_ok = 1'b1; data_rdata = 32'hFFFFFFFF;
        tick();
        data_data_ok = 1'b0;
        settle();
        check("stray_rdata", data_sram_rdata, 32'h0BADF00D);

        // Halfword write then read, read starts with addr_ok and data_ok together
        data_sram_en = 1'b1; data_sram_wen = 4'b1100; data_sram_addr = 32'h300;
        data_sram_wdata = 32'hBEEF0000; data_addr_ok = 1'b1; longest_stall = 1'b1;
        settle();
        check("hw_size", 32'(data_size), 32'd1);
        check("hw_wr", 32'(data_wr), 32'd1);
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b1;
        tick();
        data_data_ok = 1'b0; longest_stall = 1'b0;
        settle();
        check("hw_done_stall", 32'(d_stall), 32'd0);
        tick();
        data_sram_wen = 4'b0000; data_sram_addr = 32'h304; data_addr_ok = 1'b1;
        data_data_ok = 1'b1; data_rdata = 32'h11112222; longest_stall = 1'b1;
        settle();
        check("hr_size", 32'(data_size), 32'd2);
        check("hr_wr", 32'(data_wr), 32'd0);
        check("hr_req", 32'(data_req), 32'd1);
        tick();
        data_addr_ok = 1'b0;
        settle();
        check("hr_wait_stall", 32'(d_stall), 32'd1);
        tick();
        data_data_ok = 1'b0; longest_stall = 1'b0;
        settle();
        check("hr_done_rdata", data_sram_rdata, 32'h11112222);
        tick();

        // Reset while waiting for data
        data_sram_addr = 32'h400; data_addr_ok = 1'b1; longest_stall = 1'b1;
        tick();
        data_addr_ok = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0; data_sram_en = 1'b0; longest_stall = 1'b0;
        settle();
        check("rst_stall", 32'(d_stall), 32'd0);
        check("rst_req", 32'(data_req), 32'd0);
        check("rst_rdata", data_sram_rdata, 32'h0);
        tick();

        check("total_handshakes", 32'(handshakes), 32'd7);
        check("total_req_cycles", 32'(req_cycles), 32'd10);
        check("no_overlap", 32'(overlap_viol), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
